// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises a 32-bit status word (four ASCII characters) onto an 8N1 UART line.
// Characters go out most-significant byte first, and each character is sent LSB first.
// Optional feature macro: UART_TX_NEWLINE_EN. When it is defined, CR (0x0D) and LF (0x0A)
// are appended after the fourth character, and done pulses after the LF stop bit.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned NUM_BYTES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

`ifdef UART_TX_NEWLINE_EN
  localparam int unsigned NUM_CHARS = NUM_BYTES + 2;
`else
  localparam int unsigned NUM_CHARS = NUM_BYTES;
`endif
  localparam int unsigned BUF_W     = 8 * NUM_CHARS;
  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int unsigned BIT_W     = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   baud_q;
  logic [CNT_W-1:0]   baud_d;
  logic [BIT_W-1:0]   bit_q;
  logic [BIT_W-1:0]   bit_d;
  logic [IDX_W-1:0]   byte_q;
  logic [IDX_W-1:0]   byte_d;
  logic [BUF_W-1:0]   shbuf_q;
  logic [BUF_W-1:0]   shbuf_d;
  logic [BUF_W-1:0]   load_word;
  logic [7:0]         cur_byte_d;
  logic               baud_end;
  logic               last_byte;
  logic               accept;
  logic               tx_d;
  logic               ready_d;
  logic               done_d;

  // Shift buffer contents captured on accept (the terminator characters follow the word when enabled)
`ifdef UART_TX_NEWLINE_EN
  assign load_word = {word_in, 8'h0D, 8'h0A};
`else
  assign load_word = word_in;
`endif

  assign baud_end  = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_q == IDX_W'(NUM_CHARS - 1));
  assign accept    = word_valid && word_ready;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shbuf_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shbuf_q <= shbuf_d;
    end
  end

  // Next-state and datapath update: baud counter, bit and byte indices, shift buffer
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shbuf_d = shbuf_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
        if (accept) begin
          state_d = S_START;
          shbuf_d = load_word;
        end
      end
      S_START: begin
        baud_d = baud_end ? '0 : baud_q + CNT_W'(1);
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        baud_d = baud_end ? '0 : baud_q + CNT_W'(1);
        if (baud_end) begin
          if (bit_q == BIT_W'(7)) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_STOP: begin
        baud_d = baud_end ? '0 : baud_q + CNT_W'(1);
        if (baud_end) begin
          if (last_byte) begin
            state_d = S_IDLE;
          end else begin
            // The next character's start bit follows the stop bit with no idle gap
            state_d = S_START;
            byte_d  = byte_q + IDX_W'(1);
            shbuf_d = shbuf_q << 8;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state they describe
  always_comb begin
    tx_d       = 1'b1;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    cur_byte_d = shbuf_d[BUF_W-1 -: 8];
    unique case (state_d)
      S_IDLE:  begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte_d[bit_d];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  // Registered outputs; reset parks the line at idle-high and drops any in-flight word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx         <= 1'b1;
      word_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tx         <= tx_d;
      word_ready <= ready_d;
      busy       <= ~ready_d;
      done       <= done_d;
    end
  end

endmodule
